fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter sharing the single async-FIFO write port (winc/wdata, wclk domain) among NREQ write clients.
- Grants the port for bursts of up to MAXBURST beats, or up to a client's `last` beat, whichever comes first.
- Gates every beat on the FIFO's registered full flag.
- Sits in the wclk domain between the client write interfaces and the FIFO write-pointer/memory logic.

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 102 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - client/FIFO write-side bundle for the write-port arbiter
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic               wfull;
  logic [NREQ-1:0]    gnt;
  logic               winc;
  logic [DW-1:0]      wdata;
  logic               busy;
  logic [OW-1:0]      owner;

  modport master (
    output req, req_data, req_last, wfull,
    input  gnt, winc, wdata, busy, owner
  );

  modport slave (
    input  req, req_data, req_last, wfull,
    output gnt, winc, wdata, busy, owner
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the async-FIFO write port
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int MAXBURST = 4
) (
  input  logic               wclk,
  input  logic               wrst_n,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBURST) + 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [OW-1:0] r_owner, w_owner_nxt;
  logic [OW-1:0] r_last_owner, w_last_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [OW-1:0] w_sel;
  logic          w_accept;
  logic          w_release;

  logic [NREQ-1:0] w_gnt;
  logic            w_winc;
  logic [DW-1:0]   w_wdata;

  // A beat moves only while bursting, out of reset, requested and FIFO not full
  assign w_accept  = (r_state == BURST) & wrst_n & bus.req[r_owner] & ~bus.wfull;
  assign w_release = (w_accept & (bus.req_last[r_owner] | (r_cnt == CW'(MAXBURST - 1))))
                   | ((r_state == BURST) & ~bus.req[r_owner]);

  // Round-robin pick: nearest set request after the last owner; smallest offset wins
  always_comb begin
    int idx;
    idx   = 0;
    w_sel = r_last_owner;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(r_last_owner) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req[idx]) w_sel = OW'(idx);
    end
  end

  // State register; reset leaves last_owner at NREQ-1 so client 0 is scanned first
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(NREQ - 1);
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  // Next state: grant in IDLE, count beats and release in BURST
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_state_nxt = BURST;
          w_owner_nxt = w_sel;
          w_cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (w_accept) w_cnt_nxt = r_cnt + CW'(1);
        if (w_release) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_owner;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: strobe, enable and data are all zero unless a beat is accepted
  always_comb begin
    w_gnt   = '0;
    w_winc  = 1'b0;
    w_wdata = '0;
    if (w_accept) begin
      w_gnt[r_owner] = 1'b1;
      w_winc         = 1'b1;
      w_wdata        = bus.req_data[r_owner*DW +: DW];
    end
  end

  assign bus.gnt   = w_gnt;
  assign bus.winc  = w_winc;
  assign bus.wdata = w_wdata;
  assign bus.busy  = (r_state == BURST);
  assign bus.owner = r_owner;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed vector bench for the write-port arbiter
module tb_fifo_wr_arbiter;
  logic wclk;
  logic wrst_n;
  logic wrst_n3;
  int   checks;
  int   failures;

  fifo_wr_arbiter_if #(.NREQ(4), .DW(8)) b4 ();
  fifo_wr_arbiter_if #(.NREQ(3), .DW(8)) b3 ();

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAXBURST(4)) u_dut4 (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (b4)
  );

  fifo_wr_arbiter #(.NREQ(3), .DW(8), .MAXBURST(1)) u_dut3 (
    .wclk   (wclk),
    .wrst_n (wrst_n3),
    .bus    (b3)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic        wfull;
    logic [3:0]  gnt;
    logic        winc;
    logic [7:0]  wdata;
    logic        busy;
    logic [1:0]  owner;
    logic        chk;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] pk(input int c, input logic [7:0] d);
    logic [31:0] v;
    v = 32'(d);
    return v << (c * 8);
  endfunction

  task automatic addv(input logic rst_n, input logic [3:0] req, input logic [31:0] data,
                      input logic [3:0] last, input logic wfull, input logic [3:0] gnt,
                      input logic winc, input logic [7:0] wdata, input logic busy,
                      input logic [1:0] owner, input logic chk);
    vec_t v;
    v.rst_n = rst_n; v.req = req; v.data = data; v.last = last; v.wfull = wfull;
    v.gnt = gnt; v.winc = winc; v.wdata = wdata; v.busy = busy; v.owner = owner; v.chk = chk;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic [1:0] e_own;
    logic [2:0] e_gnt3;
    logic       e_winc3;
    logic [7:0] e_wd3;
    checks   = 0;
    failures = 0;
    wrst_n   = 1'b0;
    wrst_n3  = 1'b0;
    b4.req = '0; b4.req_data = '0; b4.req_last = '0; b4.wfull = 1'b0;
    b3.req = '0; b3.req_data = '0; b3.req_last = '0; b3.wfull = 1'b0;

    // reset
    addv(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
    addv(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0, 1);
    // single client, 6 beats, burst of 4 then 2
    addv(1, 4'b0010, pk(1, 8'hA0), 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0, 1);
    addv(1, 4'b0010, pk(1, 8'hA0), 4'b0000, 0, 4'b0010, 1, 8'hA0, 1, 1, 1);
    addv(1, 4'b0010, pk(1, 8'hA1), 4'b0000, 0, 4'b0010, 1, 8'hA1, 1, 1, 1);
    addv(1, 4'b0010, pk(1, 8'hA2), 4'b0000, 0, 4'b0010, 1, 8'hA2, 1, 1, 1);
    addv(1, 4'b0010, pk(1, 8'hA3), 4'b0000, 0, 4'b0010, 1, 8'hA3, 1, 1, 1);
    addv(1, 4'b0010, pk(1, 8'hA4), 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 1, 1);
    addv(1, 4'b0010, pk(1, 8'hA4), 4'b0000, 0, 4'b0010, 1, 8'hA4, 1, 1, 1);
    addv(1, 4'b0010, pk(1, 8'hA5), 4'b0010, 0, 4'b0010, 1, 8'hA5, 1, 1, 1);
    addv(1, 4'b0000, 0,            4'b0000, 0, 4'b0000, 0, 8'h00, 0, 1, 1);
    // fairness: all request, single-beat grants rotate 2,3,0,1
    addv(1, 4'b1111, 32'hB3B2B1B0, 4'b1111, 0, 4'b0000, 0, 8'h00, 0, 1, 1);
    addv(1, 4'b1111, 32'hB3B2B1B0, 4'b1111, 0, 4'b0100, 1, 8'hB2, 1, 2, 1);
    addv(1, 4'b1111, 32'hB3B2B1B0, 4'b1111, 0, 4'b0000, 0, 8'h00, 0, 2, 1);
    addv(1, 4'b1111, 32'hB3B2B1B0, 4'b1111, 0, 4'b1000, 1, 8'hB3, 1, 3, 1);
    addv(1, 4'b1111, 32'hB3B2B1B0, 4'b1111, 0, 4'b0000, 0, 8'h00, 0, 3, 1);
    addv(1, 4'b1111, 32'hB3B2B1B0, 4'b1111, 0, 4'b0001, 1, 8'hB0, 1, 0, 1);
    addv(1, 4'b1111, 32'hB3B2B1B0, 4'b1111, 0, 4'b0000, 0, 8'h00, 0, 0, 1);
    addv(1, 4'b1111, 32'hB3B2B1B0, 4'b1111, 0, 4'b0010, 1, 8'hB1, 1, 1, 1);
    addv(1, 4'b0000, 0,            4'b0000, 0, 4'b0000, 0, 8'h00, 0, 1, 1);
    // full stall on client 2 for 5 cycles after its first beat
    addv(1, 4'b0100, pk(2, 8'hC0), 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 1, 1);
    addv(1, 4'b0100, pk(2, 8'hC0), 4'b0000, 0, 4'b0100, 1, 8'hC0, 1, 2, 1);
    for (int i = 0; i < 5; i++)
      addv(1, 4'b0100, pk(2, 8'hC1), 4'b0000, 1, 4'b0000, 0, 8'h00, 1, 2, 1);
    addv(1, 4'b0100, pk(2, 8'hC1), 4'b0000, 0, 4'b0100, 1, 8'hC1, 1, 2, 1);
    addv(1, 4'b0100, pk(2, 8'hC2), 4'b0100, 0, 4'b0100, 1, 8'hC2, 1, 2, 1);
    addv(1, 4'b0000, 0,            4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2, 1);
    // withdraw: client 3 drops after 2 beats, pending client 0 granted next
    addv(1, 4'b1000, pk(3, 8'hD0), 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2, 1);
    addv(1, 4'b1001, pk(3, 8'hD0) | pk(0, 8'hE0), 4'b0001, 0, 4'b1000, 1, 8'hD0, 1, 3, 1);
    addv(1, 4'b1001, pk(3, 8'hD1) | pk(0, 8'hE0), 4'b0001, 0, 4'b1000, 1, 8'hD1, 1, 3, 1);
    addv(1, 4'b0001, pk(0, 8'hE0), 4'b0001, 0, 4'b0000, 0, 8'h00, 1, 3, 1);
    addv(1, 4'b0001, pk(0, 8'hE0), 4'b0001, 0, 4'b0000, 0, 8'h00, 0, 3, 1);
    addv(1, 4'b0001, pk(0, 8'hE0), 4'b0001, 0, 4'b0001, 1, 8'hE0, 1, 0, 1);
    addv(1, 4'b0000, 0,            4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0, 1);
    // reset mid-burst on client 1, then client 0 wins first
    addv(1, 4'b0010, pk(1, 8'hF0), 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0, 1);
    addv(1, 4'b0010, pk(1, 8'hF0), 4'b0000, 0, 4'b0010, 1, 8'hF0, 1, 1, 1);
    addv(0, 4'b0010, pk(1, 8'hF1), 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 1, 1);
    addv(1, 4'b0011, pk(1, 8'hF1) | pk(0, 8'h90), 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0, 1);
    addv(1, 4'b0011, pk(1, 8'hF1) | pk(0, 8'h90), 4'b0000, 0, 4'b0001, 1, 8'h90, 1, 0, 1);
    addv(1, 4'b0000, 0,            4'b0000, 0, 4'b0000, 0, 8'h00, 1, 0, 1);
    addv(1, 4'b0000, 0,            4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0, 1);

    foreach (vecs[i]) begin
      @(negedge wclk);
      wrst_n      = vecs[i].rst_n;
      b4.req      = vecs[i].req;
      b4.req_data = vecs[i].data;
      b4.req_last = vecs[i].last;
      b4.wfull    = vecs[i].wfull;
      #1;
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_gnt", i),   32'(b4.gnt),   32'(vecs[i].gnt));
        chk($sformatf("v%0d_winc", i),  32'(b4.winc),  32'(vecs[i].winc));
        chk($sformatf("v%0d_wdata", i), 32'(b4.wdata), 32'(vecs[i].wdata));
        chk($sformatf("v%0d_busy", i),  32'(b4.busy),  32'(vecs[i].busy));
        chk($sformatf("v%0d_owner", i), 32'(b4.owner), 32'(vecs[i].owner));
      end
    end

    // NREQ=3, MAXBURST=1: clients 0 and 2 alternate, one beat per grant
    @(negedge wclk);
    wrst_n3 = 1'b0;
    @(negedge wclk);
    #1;
    chk("n3_rst_busy",  32'(b3.busy),  0);
    chk("n3_rst_owner", 32'(b3.owner), 0);
    e_own = 2'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge wclk);
      wrst_n3     = 1'b1;
      b3.req      = 3'b101;
      b3.req_data = 24'h332211;
      b3.req_last = 3'b000;
      b3.wfull    = 1'b0;
      #1;
      if (k % 2 == 0) begin
        e_gnt3  = 3'b000;
        e_winc3 = 1'b0;
        e_wd3   = 8'h00;
      end else begin
        e_own   = ((k >> 1) % 2 == 1) ? 2'd2 : 2'd0;
        e_gnt3  = (e_own == 2'd2) ? 3'b100 : 3'b001;
        e_winc3 = 1'b1;
        e_wd3   = (e_own == 2'd2) ? 8'h33 : 8'h11;
      end
      chk($sformatf("n3_k%0d_gnt", k),   32'(b3.gnt),   32'(e_gnt3));
      chk($sformatf("n3_k%0d_winc", k),  32'(b3.winc),  32'(e_winc3));
      chk($sformatf("n3_k%0d_wdata", k), 32'(b3.wdata), 32'(e_wd3));
      chk($sformatf("n3_k%0d_busy", k),  32'(b3.busy),  32'(k % 2));
      chk($sformatf("n3_k%0d_owner", k), 32'(b3.owner), 32'(e_own));
      chk($sformatf("n3_k%0d_orng", k),  32'(b3.owner < 2'd3), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
